// File: rtl/fifo_tx_drain_ctrl_pkg.sv
// Shared definitions for the FIFO-to-UART drain sequencer: state encoding and default widths.
package fifo_tx_drain_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned GAP_WIDTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SEND      = 2'b01,
    WAIT_DONE = 2'b10,
    GAP       = 2'b11
  } drain_state_e;

endpackage

// File: rtl/fifo_tx_gap_counter.sv
// Inter-frame gap counter: loads a cycle count, decrements toward zero, flags the last gap cycle.
module fifo_tx_gap_counter #(
  parameter int unsigned Gap_width = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [Gap_width-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 tc_o
);

  logic [Gap_width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Gap_width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == Gap_width'(1));

endmodule

// File: rtl/fifo_tx_drain_ctrl.sv
// Read-domain sequencer popping FIFO words into UART_TX with a programmable inter-frame gap.
// Optional FIFO_TX_DRAIN_CNT_EN adds a popped-word counter and a sticky SEND-stall flag.
module fifo_tx_drain_ctrl
  import fifo_tx_drain_ctrl_pkg::*;
#(
  parameter int unsigned Data_width = DATA_WIDTH_DEF,
  parameter int unsigned Gap_width  = GAP_WIDTH_DEF
) (
  input  logic                  Rclk,
  input  logic                  Rrst,
  input  logic                  Enable,
  input  logic                  Rempty,
  input  logic [Data_width-1:0] Rdata,
  input  logic                  Tx_busy,
  input  logic [Gap_width-1:0]  Gap_cycles,
  output logic                  Rinc,
  output logic [Data_width-1:0] Tx_data,
  output logic                  Tx_valid,
  output logic                  Drain_active
`ifdef FIFO_TX_DRAIN_CNT_EN
  ,
  output logic [15:0]           Words_sent,
  output logic                  Tx_stall
`endif
);

  drain_state_e          state_q, state_d;
  logic                  rinc_q, rinc_d;
  logic [Data_width-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  gap_load, gap_dec, gap_tc;

  fifo_tx_gap_counter #(
    .Gap_width(Gap_width)
  ) u_gap (
    .clk_i      (Rclk),
    .rst_ni     (Rrst),
    .load_i     (gap_load),
    .load_val_i (Gap_cycles),
    .dec_i      (gap_dec),
    .tc_o       (gap_tc)
  );

  always_comb begin
    state_d  = state_q;
    rinc_d   = 1'b0;
    data_d   = data_q;
    valid_d  = valid_q;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Enable && !Rempty && !Tx_busy) begin
          state_d = SEND;
          data_d  = Rdata;
          rinc_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      SEND: begin
        if (Tx_busy) begin
          valid_d = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!Tx_busy) begin
          if (Gap_cycles == '0) begin
            state_d = IDLE;
          end else begin
            gap_load = 1'b1;
            state_d  = GAP;
          end
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        if (gap_tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Rclk or negedge Rrst) begin
    if (!Rrst) begin
      state_q <= IDLE;
      rinc_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rinc_q  <= rinc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign Rinc         = rinc_q;
  assign Tx_data      = data_q;
  assign Tx_valid     = valid_q;
  assign Drain_active = (state_q != IDLE);

`ifdef FIFO_TX_DRAIN_CNT_EN
  logic [15:0] words_q;
  logic [7:0]  send_cnt_q;
  logic        stall_q;

  // send_cnt_q holds the SEND cycles already completed, so 8'hFF marks the 256th cycle.
  always_ff @(posedge Rclk or negedge Rrst) begin
    if (!Rrst) begin
      words_q    <= '0;
      send_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (rinc_d) begin
        words_q <= words_q + 16'd1;
      end
      if (state_q == SEND) begin
        if (send_cnt_q == 8'hFF) begin
          stall_q <= 1'b1;
        end else begin
          send_cnt_q <= send_cnt_q + 8'd1;
        end
      end else begin
        send_cnt_q <= '0;
      end
    end
  end

  assign Words_sent = words_q;
  assign Tx_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fifo_tx_drain_ctrl.sv
// Bench for fifo_tx_drain_ctrl: FIFO/UART environment models plus a transaction-level reference.
module tb_fifo_tx_drain_ctrl;

  logic       Rclk = 1'b0;
  logic       Rrst;
  logic       Enable;
  logic       Rempty;
  logic [7:0] Rdata;
  logic       Tx_busy;
  logic [3:0] Gap_cycles;
  logic       Rinc;
  logic [7:0] Tx_data;
  logic       Tx_valid;
  logic       Drain_active;
`ifdef FIFO_TX_DRAIN_CNT_EN
  logic [15:0] Words_sent;
  logic        Tx_stall;
`endif

  fifo_tx_drain_ctrl #(.Data_width(8), .Gap_width(4)) dut (
    .Rclk         (Rclk),
    .Rrst         (Rrst),
    .Enable       (Enable),
    .Rempty       (Rempty),
    .Rdata        (Rdata),
    .Tx_busy      (Tx_busy),
    .Gap_cycles   (Gap_cycles),
    .Rinc         (Rinc),
    .Tx_data      (Tx_data),
    .Tx_valid     (Tx_valid),
    .Drain_active (Drain_active)
`ifdef FIFO_TX_DRAIN_CNT_EN
    ,
    .Words_sent   (Words_sent),
    .Tx_stall     (Tx_stall)
`endif
  );

  always #5 Rclk = ~Rclk;

  int n_cmp = 0;
  int n_bad = 0;

  // environment: FIFO contents and UART transmitter behaviour
  logic [7:0] fifo_q[$];
  logic [7:0] popped_log[$];
  int cyc = 0;
  int rinc_total = 0;
  int push_pct = 0;
  int tx_dly = 0, tx_len = 10;
  bit rand_tx = 0, noise_en = 0;
  bit tx_pending = 0;
  int tx_wait = 0, tx_hold = 0;

  // reference: a word is in flight from pop until its gap has elapsed
  bit         m_inflight, m_acc, m_ingap, m_rinc, m_stall;
  int         m_gap, m_words, m_sendcnt;
  logic [7:0] m_data;
  int low_cyc = -1;
  int last_idle_gap = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic model_reset();
    m_inflight = 0; m_acc = 0; m_ingap = 0; m_rinc = 0; m_stall = 0;
    m_gap = 0; m_words = 0; m_sendcnt = 0; m_data = '0;
    low_cyc = -1;
  endtask

  task automatic tx_reset();
    tx_pending = 0; tx_wait = 0; tx_hold = 0; Tx_busy = 0;
  endtask

  task automatic model_edge();
    m_rinc = 0;
    if (m_inflight && !m_acc) begin
      m_sendcnt++;
      if (m_sendcnt > 255) m_stall = 1;
    end
    if (!m_inflight) begin
      if (Enable && !Rempty && !Tx_busy) begin
        m_inflight = 1; m_acc = 0; m_ingap = 0;
        m_data = Rdata; m_rinc = 1; m_sendcnt = 0;
        m_words = (m_words + 1) % 65536;
      end
    end else if (!m_acc) begin
      if (Tx_busy) m_acc = 1;
    end else if (!m_ingap) begin
      if (!Tx_busy) begin
        low_cyc = cyc;
        if (Gap_cycles == 0) m_inflight = 0;
        else begin m_ingap = 1; m_gap = Gap_cycles; end
      end
    end else begin
      m_gap--;
      if (m_gap == 0) begin m_inflight = 0; m_ingap = 0; end
    end
  endtask

  task automatic compare();
    chk("rinc", Rinc, m_rinc);
    chk("tx_valid", Tx_valid, m_inflight && !m_acc);
    chk("tx_data", Tx_data, m_data);
    chk("drain_active", Drain_active, m_inflight);
`ifdef FIFO_TX_DRAIN_CNT_EN
    chk("words_sent", Words_sent, m_words);
    chk("tx_stall", Tx_stall, m_stall);
`endif
    if (Rinc === 1'b1) begin
      rinc_total++;
      popped_log.push_back(Tx_data);
      if (low_cyc >= 0) last_idle_gap = cyc - low_cyc - 1;
      low_cyc = -1;
    end
  endtask

  task automatic env_update(input bit pre_rinc, input bit pre_valid);
    if (pre_rinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (push_pct > 0 && fifo_q.size() < 16 && $urandom_range(0, 99) < push_pct)
      fifo_q.push_back(8'($urandom));
    Rempty = (fifo_q.size() == 0);
    Rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
    if (tx_hold > 0) begin
      tx_hold--;
      if (tx_hold == 0) Tx_busy = 0;
    end else begin
      if (!tx_pending && pre_valid && !Tx_busy) begin
        tx_pending = 1;
        if (rand_tx) begin
          tx_dly = $urandom_range(0, 3);
          tx_len = $urandom_range(1, 12);
        end
        tx_wait = tx_dly;
      end
      if (tx_pending) begin
        if (tx_wait == 0) begin
          Tx_busy = 1; tx_hold = tx_len; tx_pending = 0;
        end else tx_wait--;
      end else if (noise_en && !Tx_busy && $urandom_range(0, 99) < 3) begin
        Tx_busy = 1; tx_hold = $urandom_range(1, 3);
      end
    end
  endtask

  task automatic step();
    bit pre_rinc, pre_valid;
    pre_rinc  = Rinc;
    pre_valid = Tx_valid;
    if (Rrst) model_edge();
    @(posedge Rclk);
    #1;
    cyc++;
    compare();
    env_update(pre_rinc, pre_valid);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_fifo(input logic [7:0] w);
    fifo_q.push_back(w);
    Rempty = 0;
    Rdata  = fifo_q[0];
  endtask

  function automatic logic [7:0] logged(input int i);
    return (i < popped_log.size()) ? popped_log[i] : 8'hxx;
  endfunction

  initial begin
    bit hit;
    Rrst = 0; Enable = 1; Gap_cycles = 0;
    Tx_busy = 0; Rempty = 1; Rdata = '0;
    model_reset();
    load_fifo(8'h11);
    load_fifo(8'h22);
    #1;
    chk("reset_rinc", Rinc, 1'b0);
    chk("reset_valid", Tx_valid, 1'b0);
    chk("reset_drain", Drain_active, 1'b0);
    run(3);
    chk("reset_hold_rinc", Rinc, 1'b0);
    chk("reset_hold_valid", Tx_valid, 1'b0);
    Rrst = 1;
    step();
    chk("first_rinc", Rinc, 1'b1);
    chk("first_data", Tx_data, 8'h11);
    run(60);

    // burst of three words, no gap, TX busy one cycle after valid for 10 cycles
    rinc_total = 0; popped_log.delete();
    load_fifo(8'hA5); load_fifo(8'h3C); load_fifo(8'hFF);
    run(80);
    chk("burst_pops", rinc_total, 3);
    chk("burst_w0", logged(0), 8'hA5);
    chk("burst_w1", logged(1), 8'h3C);
    chk("burst_w2", logged(2), 8'hFF);

    // single word then empty
    rinc_total = 0;
    load_fifo(8'h5A);
    run(40);
    chk("single_pops", rinc_total, 1);
    chk("single_idle", Drain_active, 1'b0);

    // idle cycles between busy falling and the next pop
    Gap_cycles = 5; low_cyc = -1; last_idle_gap = -1;
    load_fifo(8'h01); load_fifo(8'h02);
    run(80);
    chk("gap5_spacing", last_idle_gap, 6);
    Gap_cycles = 0; low_cyc = -1; last_idle_gap = -1;
    load_fifo(8'h03); load_fifo(8'h04);
    run(60);
    chk("gap0_spacing", last_idle_gap, 1);

    // Enable dropped while waiting for TX to finish
    Gap_cycles = 2;
    load_fifo(8'h10); load_fifo(8'h20); load_fifo(8'h30);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step();
      hit = Drain_active && !Tx_valid && Tx_busy;
    end
    if (!hit) timeout("wait_done_reach");
    Enable = 0;
    rinc_total = 0;
    run(60);
    chk("disabled_pops", rinc_total, 0);
    chk("disabled_idle", Drain_active, 1'b0);
    chk("disabled_queue", fifo_q.size(), 2);
    Enable = 1;
    run(80);
    chk("resumed_pops", rinc_total, 2);

    // asynchronous reset while a word sits in SEND
    Gap_cycles = 0; tx_dly = 4;
    load_fifo(8'hC3); load_fifo(8'h7E);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = Rinc;
    end
    if (!hit) timeout("send_reach");
    #3 Rrst = 0;
    #1;
    chk("arst_rinc", Rinc, 1'b0);
    chk("arst_valid", Tx_valid, 1'b0);
    chk("arst_data", Tx_data, 8'h00);
    chk("arst_drain", Drain_active, 1'b0);
`ifdef FIFO_TX_DRAIN_CNT_EN
    chk("arst_words", Words_sent, 16'd0);
`endif
    model_reset(); tx_reset();
    run(2);
    Rrst = 1;
    rinc_total = 0; popped_log.delete();
    run(50);
    chk("post_rst_pops", rinc_total, 2);
    chk("post_rst_w0", logged(0), 8'hC3);
`ifdef FIFO_TX_DRAIN_CNT_EN
    chk("post_rst_words", Words_sent, 16'd2);
    // a transmitter that never answers trips the stall flag
    tx_dly = 300;
    load_fifo(8'h99);
    run(320);
    chk("stall_set", Tx_stall, 1'b1);
    #2 Rrst = 0;
    #1;
    chk("stall_cleared", Tx_stall, 1'b0);
    model_reset(); tx_reset();
    fifo_q.delete(); Rempty = 1;
    run(2);
    Rrst = 1;
`endif

    // randomized traffic
    tx_dly = 0; rand_tx = 1; noise_en = 1; push_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 5) Enable = ~Enable;
      if ($urandom_range(0, 99) < 2) Gap_cycles = 4'($urandom_range(0, 15));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
